// File: rtl/memory_access_if.sv
`default_nettype none
// ============================================================================
// Module      : memory_access_if
// Description : Data-memory request/ready port between the MEM stage
//               (master) and the data memory (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface memory_access_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_be,
        output dmem_addr,
        output dmem_wdata,
        input  dmem_ready,
        input  dmem_rdata
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_be,
        input  dmem_addr,
        input  dmem_wdata,
        output dmem_ready,
        output dmem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/memory_access.sv
`default_nettype none
// ============================================================================
// Module      : memory_access
// Description : Pipeline MEM stage - drives the data-memory port, aligns load
//               data, replicates store lanes, stalls EX while an access is
//               outstanding and aborts accesses that never complete.
//               Optional: MEM_MISALIGN_TRAP_EN traps misaligned H/W accesses.
// Revision    : 1.0 - initial release
// ============================================================================
module memory_access #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic [31:0] EX_MEM_ALU_OUT,
    input  wire logic [31:0] EX_MEM_writedata,
    input  wire logic [2:0]  EX_MEM_funct3,
    input  wire logic        EX_MEM_memwrite_en,
    input  wire logic        EX_MEM_wb_sel,
    input  wire logic        EX_MEM_regwrite_en,
    input  wire logic [4:0]  EX_MEM_RD,
    memory_access_if.master  dmem,
    output logic             mem_stall,
    output logic [31:0]      MEM_WB_RESULT,
    output logic [4:0]       MEM_WB_RD,
    output logic             MEM_WB_regwrite_en,
    output logic             bus_err,
    output logic             misalign_err
);

    localparam int       c_CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [1:0] c_SZ_B = 2'b00;
    localparam logic [1:0] c_SZ_H = 2'b01;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t              r_state;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [31:0]         r_result;
    logic [4:0]          r_rd;
    logic                r_regwrite;
    logic                r_bus_err;

    logic                w_mem_op;
    logic                w_is_load;
    logic                w_trap;
    logic                w_req;
    logic [1:0]          w_lane;
    logic [1:0]          w_size;
    logic [7:0]          w_byte;
    logic [15:0]         w_half;
    logic [31:0]         w_load_data;
    logic [3:0]          w_store_be;
    logic [31:0]         w_store_data;
    logic [c_CNT_W-1:0]  w_cnt_next;
    logic                w_timeout;

    // A store wins when both memwrite_en and wb_sel are set.
    assign w_mem_op  = EX_MEM_memwrite_en | EX_MEM_wb_sel;
    assign w_is_load = EX_MEM_wb_sel & ~EX_MEM_memwrite_en;
    assign w_lane    = EX_MEM_ALU_OUT[1:0];
    assign w_size    = EX_MEM_funct3[1:0];

    assign w_byte = dmem.dmem_rdata[{w_lane, 3'b000} +: 8];
    assign w_half = dmem.dmem_rdata[{w_lane[1], 4'b0000} +: 16];

    always_comb begin
        w_load_data = dmem.dmem_rdata;
        case (w_size)
            c_SZ_B:  w_load_data = {{24{~EX_MEM_funct3[2] & w_byte[7]}}, w_byte};
            c_SZ_H:  w_load_data = {{16{~EX_MEM_funct3[2] & w_half[15]}}, w_half};
            default: w_load_data = dmem.dmem_rdata;
        endcase
    end

    always_comb begin
        w_store_be   = 4'b1111;
        w_store_data = EX_MEM_writedata;
        case (w_size)
            c_SZ_B: begin
                w_store_be   = 4'b0001 << w_lane;
                w_store_data = {4{EX_MEM_writedata[7:0]}};
            end
            c_SZ_H: begin
                w_store_be   = 4'b0011 << {w_lane[1], 1'b0};
                w_store_data = {2{EX_MEM_writedata[15:0]}};
            end
            default: begin
                w_store_be   = 4'b1111;
                w_store_data = EX_MEM_writedata;
            end
        endcase
    end

`ifdef MEM_MISALIGN_TRAP_EN
    logic w_misaligned;
    logic r_misalign;

    always_comb begin
        w_misaligned = 1'b0;
        case (w_size)
            c_SZ_B:  w_misaligned = 1'b0;
            c_SZ_H:  w_misaligned = w_lane[0];
            default: w_misaligned = (w_lane != 2'b00);
        endcase
    end

    assign w_trap = w_mem_op & w_misaligned & (r_state == S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= w_trap;
        end
    end

    assign misalign_err = r_misalign;
`else
    assign w_trap       = 1'b0;
    assign misalign_err = 1'b0;
`endif

    assign w_req = ~rst & ((r_state == S_WAIT) | (w_mem_op & ~w_trap));

    assign dmem.dmem_req   = w_req;
    assign dmem.dmem_we    = EX_MEM_memwrite_en;
    assign dmem.dmem_be    = EX_MEM_memwrite_en ? w_store_be : 4'b1111;
    assign dmem.dmem_addr  = {EX_MEM_ALU_OUT[31:2], 2'b00};
    assign dmem.dmem_wdata = w_store_data;

    assign mem_stall = w_req & ~dmem.dmem_ready;

    // The count is the number of not-ready cycles seen including this one, so
    // the abort lands on the TIMEOUT_CYCLES-th consecutive stalled cycle.
    assign w_cnt_next = (r_state == S_IDLE) ? c_CNT_W'(1) : (r_cnt + c_CNT_W'(1));
    assign w_timeout  = (TIMEOUT_CYCLES != 0) && (w_cnt_next == c_CNT_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_result   <= '0;
            r_rd       <= '0;
            r_regwrite <= 1'b0;
            r_bus_err  <= 1'b0;
        end else begin
            r_bus_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_trap) begin
                        r_regwrite <= 1'b0;
                    end else if (!w_mem_op || dmem.dmem_ready) begin
                        r_result   <= (w_mem_op && w_is_load) ? w_load_data : EX_MEM_ALU_OUT;
                        r_rd       <= EX_MEM_RD;
                        r_regwrite <= EX_MEM_regwrite_en;
                    end else if (w_timeout) begin
                        r_bus_err  <= 1'b1;
                        r_regwrite <= 1'b0;
                        r_cnt      <= '0;
                    end else begin
                        r_state    <= S_WAIT;
                        r_cnt      <= w_cnt_next;
                        r_regwrite <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (dmem.dmem_ready) begin
                        r_state    <= S_IDLE;
                        r_cnt      <= '0;
                        r_result   <= w_is_load ? w_load_data : EX_MEM_ALU_OUT;
                        r_rd       <= EX_MEM_RD;
                        r_regwrite <= EX_MEM_regwrite_en;
                    end else if (w_timeout) begin
                        r_state    <= S_IDLE;
                        r_cnt      <= '0;
                        r_bus_err  <= 1'b1;
                        r_regwrite <= 1'b0;
                    end else begin
                        r_cnt      <= w_cnt_next;
                        r_regwrite <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_cnt      <= '0;
                    r_regwrite <= 1'b0;
                end
            endcase
        end
    end

    assign MEM_WB_RESULT      = r_result;
    assign MEM_WB_RD          = r_rd;
    assign MEM_WB_regwrite_en = r_regwrite;
    assign bus_err            = r_bus_err;

endmodule
`default_nettype wire

// File: tb/tb_memory_access.sv
`default_nettype none
// ============================================================================
// Module      : tb_memory_access
// Description : Directed self-checking bench for memory_access with a
//               writeback scoreboard. Honours MEM_MISALIGN_TRAP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_access;

    logic        clk;
    logic        rst;
    logic [31:0] alu_out;
    logic [31:0] writedata;
    logic [2:0]  funct3;
    logic        memwrite_en;
    logic        wb_sel;
    logic        regwrite_en;
    logic [4:0]  rd;
    logic        mem_stall;
    logic [31:0] wb_result;
    logic [4:0]  wb_rd;
    logic        wb_regwrite;
    logic        bus_err;
    logic        misalign_err;

    int n_errors = 0;
    int n_checks = 0;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        we;
        logic        chk_res;
    } wb_t;

    wb_t sb[$];

    memory_access_if dmem_bus ();

    memory_access #(.TIMEOUT_CYCLES(16)) dut (
        .clk                (clk),
        .rst                (rst),
        .EX_MEM_ALU_OUT     (alu_out),
        .EX_MEM_writedata   (writedata),
        .EX_MEM_funct3      (funct3),
        .EX_MEM_memwrite_en (memwrite_en),
        .EX_MEM_wb_sel      (wb_sel),
        .EX_MEM_regwrite_en (regwrite_en),
        .EX_MEM_RD          (rd),
        .dmem               (dmem_bus.master),
        .mem_stall          (mem_stall),
        .MEM_WB_RESULT      (wb_result),
        .MEM_WB_RD          (wb_rd),
        .MEM_WB_regwrite_en (wb_regwrite),
        .bus_err            (bus_err),
        .misalign_err       (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3,
                         input logic we, input logic wbs, input logic rw, input logic [4:0] r,
                         input logic rdy, input logic [31:0] rdat);
        alu_out             = a;
        writedata           = d;
        funct3              = f3;
        memwrite_en         = we;
        wb_sel              = wbs;
        regwrite_en         = rw;
        rd                  = r;
        dmem_bus.dmem_ready = rdy;
        dmem_bus.dmem_rdata = rdat;
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] res, input logic [4:0] r, input logic we, input logic cr);
        wb_t e;
        e.res = res; e.rd = r; e.we = we; e.chk_res = cr;
        sb.push_back(e);
    endtask

    task automatic pop_check(input string tag);
        wb_t e;
        if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $error("FAIL %s_sb: observed=empty expected=entry", tag);
        end else begin
            e = sb.pop_front();
            if (e.chk_res) chk({tag, "_result"}, wb_result, e.res);
            chk({tag, "_rd"}, {27'd0, wb_rd}, {27'd0, e.rd});
            chk({tag, "_regwrite"}, {31'd0, wb_regwrite}, {31'd0, e.we});
        end
    endtask

    logic [31:0] ld_addr  [8];
    logic [2:0]  ld_f3    [8];
    logic [31:0] ld_rdata [8];
    logic [31:0] ld_exp   [8];
    logic [31:0] st_addr  [5];
    logic [2:0]  st_f3    [5];
    logic [31:0] st_data  [5];
    logic [3:0]  st_be    [5];
    logic [31:0] st_wdata [5];
    logic        st_wbs   [5];

    int stalls;
    int errs;
    int wbs;

    initial begin
        ld_addr  = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h100, 32'h101, 32'h100, 32'h104};
        ld_f3    = '{3'b000, 3'b100, 3'b101, 3'b001, 3'b000, 3'b100, 3'b001, 3'b010};
        ld_rdata = '{32'h80FF0000, 32'h80FF0000, 32'h80FF0000, 32'h80FF0000,
                     32'h1234567F, 32'h1234A57F, 32'h0000F00D, 32'hDEADBEEF};
        ld_exp   = '{32'hFFFFFF80, 32'h00000080, 32'h000080FF, 32'hFFFF80FF,
                     32'h0000007F, 32'h000000A5, 32'hFFFFF00D, 32'hDEADBEEF};
        st_addr  = '{32'h101, 32'h103, 32'h100, 32'h108, 32'h10E};
        st_f3    = '{3'b000, 3'b000, 3'b001, 3'b010, 3'b001};
        st_data  = '{32'h000000A5, 32'h11223344, 32'hABCD1234, 32'hCAFEF00D, 32'h00005A6B};
        st_be    = '{4'b0010, 4'b1000, 4'b0011, 4'b1111, 4'b1100};
        st_wdata = '{32'hA5A5A5A5, 32'h44444444, 32'h12341234, 32'hCAFEF00D, 32'h5A6B5A6B};
        st_wbs   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        // Reset: a pending load must not reach the bus while rst is high.
        rst = 1'b1;
        drive(32'h40, 32'h0, 3'b010, 1'b0, 1'b1, 1'b1, 5'd1, 1'b0, 32'h0);
        chk("rst_req", {31'd0, dmem_bus.dmem_req}, 32'd0);
        chk("rst_stall", {31'd0, mem_stall}, 32'd0);
        tick();
        chk("rst_result", wb_result, 32'd0);
        chk("rst_rd", {27'd0, wb_rd}, 32'd0);
        chk("rst_regwrite", {31'd0, wb_regwrite}, 32'd0);
        chk("rst_bus_err", {31'd0, bus_err}, 32'd0);
        chk("rst_misalign", {31'd0, misalign_err}, 32'd0);
        rst = 1'b0;

        // Plain ALU result passes through with one cycle latency.
        drive(32'h00001234, 32'h0, 3'b000, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 32'h0);
        chk("alu_req", {31'd0, dmem_bus.dmem_req}, 32'd0);
        chk("alu_stall", {31'd0, mem_stall}, 32'd0);
        push(32'h00001234, 5'd5, 1'b1, 1'b1);
        tick();
        pop_check("alu");

        // Loads completing in the request cycle.
        for (int i = 0; i < 8; i++) begin
            drive(ld_addr[i], 32'h0, ld_f3[i], 1'b0, 1'b1, 1'b1, 5'(i + 10), 1'b1, ld_rdata[i]);
            chk($sformatf("ld%0d_req", i), {31'd0, dmem_bus.dmem_req}, 32'd1);
            chk($sformatf("ld%0d_stall", i), {31'd0, mem_stall}, 32'd0);
            chk($sformatf("ld%0d_addr", i), dmem_bus.dmem_addr, {ld_addr[i][31:2], 2'b00});
            chk($sformatf("ld%0d_be", i), {28'd0, dmem_bus.dmem_be}, 32'hF);
            push(ld_exp[i], 5'(i + 10), 1'b1, 1'b1);
            tick();
            pop_check($sformatf("ld%0d", i));
        end

        // Stores completing in the request cycle (last one has wb_sel set too).
        for (int i = 0; i < 5; i++) begin
            drive(st_addr[i], st_data[i], st_f3[i], 1'b1, st_wbs[i], 1'b0, 5'd9, 1'b1, 32'h0);
            chk($sformatf("st%0d_we", i), {31'd0, dmem_bus.dmem_we}, 32'd1);
            chk($sformatf("st%0d_be", i), {28'd0, dmem_bus.dmem_be}, {28'd0, st_be[i]});
            chk($sformatf("st%0d_wdata", i), dmem_bus.dmem_wdata, st_wdata[i]);
            push(32'h0, 5'd9, 1'b0, 1'b0);
            tick();
            pop_check($sformatf("st%0d", i));
        end

        // SH with ready arriving after three stalled cycles.
        drive(32'h102, 32'hABCD1234, 3'b001, 1'b1, 1'b0, 1'b0, 5'd9, 1'b0, 32'h0);
        stalls = 0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("sh_req%0d", k), {31'd0, dmem_bus.dmem_req}, 32'd1);
            chk($sformatf("sh_addr%0d", k), dmem_bus.dmem_addr, 32'h100);
            chk($sformatf("sh_be%0d", k), {28'd0, dmem_bus.dmem_be}, 32'hC);
            chk($sformatf("sh_wdata%0d", k), dmem_bus.dmem_wdata, 32'h12341234);
            if (mem_stall) stalls++;
            tick();
            chk($sformatf("sh_bubble%0d", k), {31'd0, wb_regwrite}, 32'd0);
        end
        dmem_bus.dmem_ready = 1'b1;
        #1;
        chk("sh_stall_release", {31'd0, mem_stall}, 32'd0);
        chk("sh_req_hold", {31'd0, dmem_bus.dmem_req}, 32'd1);
        push(32'h0, 5'd9, 1'b0, 1'b0);
        tick();
        pop_check("sh");
        chk("sh_stall_cycles", stalls, 32'd3);

        // Load that never completes must abort after 16 stalled cycles.
        drive(32'h200, 32'h0, 3'b010, 1'b0, 1'b1, 1'b1, 5'd3, 1'b0, 32'h0);
        stalls = 0; errs = 0; wbs = 0;
        for (int k = 0; k < 40; k++) begin
            if (!mem_stall) break;
            stalls++;
            tick();
            if (wb_regwrite) wbs++;
            if (bus_err) begin
                errs++;
                drive(32'h0000CAFE, 32'h0, 3'b000, 1'b0, 1'b0, 1'b1, 5'd4, 1'b0, 32'h0);
            end
        end
        chk("to_stall_cycles", stalls, 32'd16);
        chk("to_bus_err_pulses", errs, 32'd1);
        chk("to_writebacks", wbs, 32'd0);
        chk("to_stall_after", {31'd0, mem_stall}, 32'd0);
        push(32'h0000CAFE, 5'd4, 1'b1, 1'b1);
        tick();
        pop_check("to_alu");
        chk("to_bus_err_clear", {31'd0, bus_err}, 32'd0);

        // Reset in the middle of a wait abandons the access quietly.
        drive(32'h300, 32'h0, 3'b010, 1'b0, 1'b1, 1'b1, 5'd6, 1'b0, 32'h0);
        tick(); tick(); tick();
        chk("rw_stall", {31'd0, mem_stall}, 32'd1);
        rst = 1'b1;
        tick();
        chk("rw_req_in_rst", {31'd0, dmem_bus.dmem_req}, 32'd0);
        chk("rw_bus_err", {31'd0, bus_err}, 32'd0);
        chk("rw_regwrite", {31'd0, wb_regwrite}, 32'd0);
        rst = 1'b0;
        drive(32'h0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0);
        chk("rw_idle_req", {31'd0, dmem_bus.dmem_req}, 32'd0);
        chk("rw_idle_stall", {31'd0, mem_stall}, 32'd0);
        tick();
        chk("rw_bus_err_after", {31'd0, bus_err}, 32'd0);
        drive(32'h00000055, 32'h0, 3'b000, 1'b0, 1'b0, 1'b1, 5'd2, 1'b0, 32'h0);
        push(32'h00000055, 5'd2, 1'b1, 1'b1);
        tick();
        pop_check("rw_alu");

        // Misaligned LW.
        drive(32'h101, 32'h0, 3'b010, 1'b0, 1'b1, 1'b1, 5'd8, 1'b1, 32'h11223344);
`ifdef MEM_MISALIGN_TRAP_EN
        chk("mis_req", {31'd0, dmem_bus.dmem_req}, 32'd0);
        chk("mis_stall", {31'd0, mem_stall}, 32'd0);
        tick();
        chk("mis_err", {31'd0, misalign_err}, 32'd1);
        chk("mis_regwrite", {31'd0, wb_regwrite}, 32'd0);
        drive(32'h0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0);
        tick();
        chk("mis_err_pulse", {31'd0, misalign_err}, 32'd0);
`else
        chk("mis_req", {31'd0, dmem_bus.dmem_req}, 32'd1);
        chk("mis_addr", dmem_bus.dmem_addr, 32'h100);
        chk("mis_be", {28'd0, dmem_bus.dmem_be}, 32'hF);
        push(32'h11223344, 5'd8, 1'b1, 1'b1);
        tick();
        pop_check("mis");
        chk("mis_err", {31'd0, misalign_err}, 32'd0);
`endif

        chk("sb_drained", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
